// File: rtl/bt656_pkg.sv
// Shared types and constants for the BT.656 line writer.
// XY protection checking in bt656_trs_detect is enabled by defining BT656_XY_CHECK_EN.
package bt656_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        ACTIVE = 2'd1,
        SKIP   = 2'd2
    } state_t;

    localparam logic [7:0] TRS_PRE0 = 8'hFF;
    localparam logic [7:0] TRS_PRE1 = 8'h00;

    localparam int F_BIT = 6;
    localparam int V_BIT = 5;
    localparam int H_BIT = 4;

    // Protection bits of the XY word: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H
    function automatic logic xy_ok(input logic [7:0] xy);
        logic       f_s;
        logic       v_s;
        logic       h_s;
        logic [3:0] p_s;
        f_s = xy[F_BIT];
        v_s = xy[V_BIT];
        h_s = xy[H_BIT];
        p_s = {v_s ^ h_s, f_s ^ h_s, f_s ^ v_s, f_s ^ v_s ^ h_s};
        return (xy[3:0] == p_s);
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// TRS detector: 3-byte shifter of valid bytes plus XY decode.
// Define BT656_XY_CHECK_EN to reject TRS codes whose protection bits mismatch.
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       sav_stb,
    output logic       eav_stb,
    output logic       f,
    output logic       v
);

    logic [7:0] sh0_r;
    logic [7:0] sh1_r;
    logic [7:0] sh2_r;
    logic       pre_s;
    logic       xy_good_s;
    logic       trs_s;

    // Shift history only advances on valid bytes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh0_r <= 8'h00;
            sh1_r <= 8'h00;
            sh2_r <= 8'h00;
        end else if (data_valid) begin
            sh0_r <= sh1_r;
            sh1_r <= sh2_r;
            sh2_r <= data_in;
        end else begin
            sh0_r <= sh0_r;
            sh1_r <= sh1_r;
            sh2_r <= sh2_r;
        end
    end

    // Preamble match and XY qualification for the current byte
    always_comb begin
        pre_s = (sh0_r == TRS_PRE0) && (sh1_r == TRS_PRE1) && (sh2_r == TRS_PRE1);
`ifdef BT656_XY_CHECK_EN
        xy_good_s = xy_ok(data_in);
`else
        xy_good_s = 1'b1;
`endif
        trs_s   = data_valid && pre_s && data_in[7] && xy_good_s;
        sav_stb = trs_s && !data_in[H_BIT];
        eav_stb = trs_s && data_in[H_BIT];
        f       = data_in[F_BIT];
        v       = data_in[V_BIT];
    end

endmodule

// File: rtl/bt656_line_writer.sv
// Writes whole BT.656 active lines into the line FIFO, dropping complete lines at SAV when it is full.
// Build option: BT656_XY_CHECK_EN enables TRS protection-bit checking in the detector.
module bt656_line_writer
    import bt656_pkg::*;
#(
    parameter int LINE_BYTES = 1440,
    parameter int CNT_W      = 11,
    parameter int DROP_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    input  logic              fifo_full,
    output logic [7:0]        fifo_data,
    output logic              fifo_write,
    output logic              field,
    output logic              vblank,
    output logic              line_done,
    output logic              short_line_err,
    output logic              overrun_err,
    output logic [DROP_W-1:0] lines_dropped
);

    localparam logic [CNT_W-1:0] LINE_MAX = CNT_W'(LINE_BYTES);

    logic sav_s;
    logic eav_s;
    logic f_s;
    logic v_s;
    logic trs_s;
    logic room_s;

    state_t            state_r,  state_nx;
    logic [CNT_W-1:0]  cnt_r,    cnt_nx;
    logic [DROP_W-1:0] drop_r,   drop_nx;
    logic [7:0]        data_r,   data_nx;
    logic              wr_r,     wr_nx;
    logic              field_r,  field_nx;
    logic              vblank_r, vblank_nx;
    logic              done_r,   done_nx;
    logic              short_r,  short_nx;
    logic              ovr_r,    ovr_nx;

    bt656_trs_detect u_trs (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .sav_stb    (sav_s),
        .eav_stb    (eav_s),
        .f          (f_s),
        .v          (v_s)
    );

    assign trs_s  = sav_s || eav_s;
    assign room_s = (cnt_r < LINE_MAX);

    // State, counters and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= BLANK;
            cnt_r    <= '0;
            drop_r   <= '0;
            data_r   <= 8'h00;
            wr_r     <= 1'b0;
            field_r  <= 1'b0;
            vblank_r <= 1'b0;
            done_r   <= 1'b0;
            short_r  <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            drop_r   <= drop_nx;
            data_r   <= data_nx;
            wr_r     <= wr_nx;
            field_r  <= field_nx;
            vblank_r <= vblank_nx;
            done_r   <= done_nx;
            short_r  <= short_nx;
            ovr_r    <= ovr_nx;
        end
    end

    // Line sequencing: close the current line on any TRS, then apply SAV admit/drop rules
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        drop_nx   = drop_r;
        data_nx   = data_r;
        wr_nx     = 1'b0;
        field_nx  = field_r;
        vblank_nx = vblank_r;
        done_nx   = 1'b0;
        short_nx  = 1'b0;
        ovr_nx    = 1'b0;

        if (data_valid) begin
            if (trs_s) begin
                field_nx  = f_s;
                vblank_nx = v_s;
            end else begin
                field_nx  = field_r;
                vblank_nx = vblank_r;
            end

            case (state_r)
                ACTIVE: begin
                    if (trs_s) begin
                        state_nx = BLANK;
                        done_nx  = 1'b1;
                        short_nx = room_s;
                    end else if (room_s) begin
                        wr_nx   = 1'b1;
                        data_nx = data_in;
                        cnt_nx  = cnt_r + CNT_W'(1);
                        ovr_nx  = fifo_full;
                    end else begin
                        cnt_nx = cnt_r;
                    end
                end
                SKIP: begin
                    if (trs_s) begin
                        state_nx = BLANK;
                    end else begin
                        state_nx = SKIP;
                    end
                end
                BLANK: begin
                    state_nx = BLANK;
                end
                default: begin
                    state_nx = BLANK;
                end
            endcase

            // A SAV seen mid-line has already closed that line above
            if (sav_s && !v_s) begin
                if (!fifo_full) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                end else begin
                    state_nx = SKIP;
                    drop_nx  = (drop_r == '1) ? drop_r : drop_r + DROP_W'(1);
                end
            end else begin
                drop_nx = drop_r;
            end
        end else begin
            wr_nx = 1'b0;
        end
    end

    assign fifo_data      = data_r;
    assign fifo_write     = wr_r;
    assign field          = field_r;
    assign vblank         = vblank_r;
    assign line_done      = done_r;
    assign short_line_err = short_r;
    assign overrun_err    = ovr_r;
    assign lines_dropped  = drop_r;

endmodule

// File: tb/tb_bt656_line_writer.sv
// Self-checking bench for bt656_line_writer: scoreboard of expected FIFO bytes plus per-scenario tasks.
module tb_bt656_line_writer;

    localparam int LB = 1440;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          fifo_full;
    logic [7:0]    fifo_data;
    logic          fifo_write;
    logic          field;
    logic          vblank;
    logic          line_done;
    logic          short_line_err;
    logic          overrun_err;
    logic [DW-1:0] lines_dropped;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int short_cnt = 0;
    int ovr_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    bit         line_open = 1'b0;
    int         line_cnt = 0;

    // Drop counter narrowed so that saturation is reachable in a short run
    bt656_line_writer #(.LINE_BYTES(LB), .CNT_W(11), .DROP_W(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .fifo_full      (fifo_full),
        .fifo_data      (fifo_data),
        .fifo_write     (fifo_write),
        .field          (field),
        .vblank         (vblank),
        .line_done      (line_done),
        .short_line_err (short_line_err),
        .overrun_err    (overrun_err),
        .lines_dropped  (lines_dropped)
    );

    always #5 clock = ~clock;

    // Output monitor: pops the scoreboard on each write and tallies pulses
    always @(negedge clock) begin
        if (reset_n && fifo_write) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data %02h, required no write", fifo_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (fifo_data !== exp_b) begin
                    errors++;
                    $display("FAIL fifo_data: got %02h, required %02h", fifo_data, exp_b);
                end
            end
        end
        if (reset_n && line_done)      done_cnt++;
        if (reset_n && short_line_err) short_cnt++;
        if (reset_n && overrun_err)    ovr_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            data_valid = 1'b0;
            data_in    = 8'hFF;
        end
    endtask

    task automatic clear_counts();
        wr_cnt    = 0;
        done_cnt  = 0;
        short_cnt = 0;
        ovr_cnt   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        @(negedge clock);
        data_in    = b;
        data_valid = 1'b1;
        if (gap) begin
            @(negedge clock);
            data_valid = 1'b0;
            data_in    = 8'hFF;
        end
    endtask

    // Expected behaviour of one data byte inside an admitted line
    task automatic model_data(input logic [7:0] b);
        if (line_open && line_cnt < LB) begin
            exp_q.push_back(b);
            line_cnt++;
        end
    endtask

    task automatic send_trs(input logic [7:0] xy, input bit gap, input bit accept);
        model_data(8'hFF);
        send_byte(8'hFF, gap);
        model_data(8'h00);
        send_byte(8'h00, gap);
        model_data(8'h00);
        send_byte(8'h00, gap);
        if (accept) begin
            line_open = (xy[4] == 1'b0) && (xy[5] == 1'b0) && (fifo_full == 1'b0);
            line_cnt  = 0;
        end else begin
            model_data(xy);
        end
        send_byte(xy, gap);
    endtask

    task automatic send_data(input int n, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'h10 + 8'(i % 220);
            model_data(b);
            send_byte(b, gap);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        fifo_full  = 1'b0;
        idle(3);
        checks++;
        if ({fifo_write, fifo_data, field, vblank, line_done, short_line_err, overrun_err, lines_dropped} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b data=%02h f=%b v=%b drop=%0d, required all 0",
                     fifo_write, fifo_data, field, vblank, lines_dropped);
        end
        reset_n = 1'b1;
        idle(3);
        checks++;
        if ({fifo_write, line_done, lines_dropped} !== '0) begin
            errors++;
            $display("FAIL after_release: got wr=%b done=%b drop=%0d, required 0", fifo_write, line_done, lines_dropped);
        end
        clear_counts();
    endtask

    task automatic test_full_line();
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(LB, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== LB) begin errors++; $display("FAIL full_writes: got %0d, required %0d", wr_cnt, LB); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done: got %0d, required 1", done_cnt); end
        checks++; if (short_cnt + ovr_cnt !== 0) begin errors++; $display("FAIL full_errs: got short=%0d ovr=%0d, required 0", short_cnt, ovr_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL full_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(100, 1'b0);
        fifo_full = 1'b1;
        send_data(10, 1'b0);
        fifo_full = 1'b0;
        send_data(LB - 110, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (ovr_cnt !== 10) begin errors++; $display("FAIL overrun_pulses: got %0d, required 10", ovr_cnt); end
        checks++; if (wr_cnt !== LB) begin errors++; $display("FAIL overrun_writes: got %0d, required %0d", wr_cnt, LB); end
    endtask

    task automatic test_drop();
        clear_counts();
        checks++; if (lines_dropped !== 8'd0) begin errors++; $display("FAIL drop_init: got %0d, required 0", lines_dropped); end
        fifo_full = 1'b1;
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(200, 1'b0);
        idle(2);
        checks++; if (lines_dropped !== 8'd1) begin errors++; $display("FAIL drop_one: got %0d, required 1", lines_dropped); end
        for (int i = 0; i < 254; i++) send_trs(8'h80, 1'b0, 1'b1);
        idle(2);
        checks++; if (lines_dropped !== 8'hFF) begin errors++; $display("FAIL drop_full: got %0d, required 255", lines_dropped); end
        send_trs(8'h80, 1'b0, 1'b1);
        idle(2);
        checks++; if (lines_dropped !== 8'hFF) begin errors++; $display("FAIL drop_saturate: got %0d, required 255", lines_dropped); end
        send_trs(8'h9D, 1'b0, 1'b1);
        fifo_full = 1'b0;
        idle(3);
        checks++; if (wr_cnt + done_cnt !== 0) begin errors++; $display("FAIL drop_activity: got wr=%0d done=%0d, required 0", wr_cnt, done_cnt); end
    endtask

    task automatic test_short_long();
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(1000, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== 1003) begin errors++; $display("FAIL short_writes: got %0d, required 1003", wr_cnt); end
        checks++; if (short_cnt !== 1 || done_cnt !== 1) begin errors++; $display("FAIL short_flags: got short=%0d done=%0d, required 1/1", short_cnt, done_cnt); end
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(1500, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== LB) begin errors++; $display("FAIL long_writes: got %0d, required %0d", wr_cnt, LB); end
        checks++; if (short_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL long_flags: got short=%0d done=%0d, required 0/1", short_cnt, done_cnt); end
    endtask

    task automatic test_vblank_field();
        clear_counts();
        send_trs(8'hAB, 1'b0, 1'b1);
        idle(1);
        checks++; if (vblank !== 1'b1 || field !== 1'b0) begin errors++; $display("FAIL vblank_bits: got v=%b f=%b, required 1/0", vblank, field); end
        send_data(200, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt + done_cnt !== 0) begin errors++; $display("FAIL vblank_writes: got wr=%0d done=%0d, required 0", wr_cnt, done_cnt); end
        send_trs(8'hC7, 1'b0, 1'b1);
        idle(1);
        checks++; if (field !== 1'b1 || vblank !== 1'b0) begin errors++; $display("FAIL field_bits: got f=%b v=%b, required 1/0", field, vblank); end
        send_data(LB, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== LB || done_cnt !== 1) begin errors++; $display("FAIL field_writes: got wr=%0d done=%0d, required %0d/1", wr_cnt, done_cnt, LB); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(500, 1'b0);
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(LB, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== 503 + LB) begin errors++; $display("FAIL b2b_writes: got %0d, required %0d", wr_cnt, 503 + LB); end
        checks++; if (done_cnt !== 2 || short_cnt !== 1) begin errors++; $display("FAIL b2b_flags: got done=%0d short=%0d, required 2/1", done_cnt, short_cnt); end
    endtask

    task automatic test_gaps();
        clear_counts();
        send_trs(8'h80, 1'b1, 1'b1);
        send_data(LB, 1'b1);
        send_trs(8'h9D, 1'b1, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== LB || done_cnt !== 1 || short_cnt !== 0) begin
            errors++; $display("FAIL gap_line: got wr=%0d done=%0d short=%0d, required %0d/1/0", wr_cnt, done_cnt, short_cnt, LB);
        end
    endtask

    task automatic test_reset_mid_line();
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(700, 1'b0);
        @(negedge clock);
        data_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        line_open = 1'b0;
        checks++;
        if ({fifo_write, fifo_data, field, vblank, line_done, short_line_err, overrun_err, lines_dropped} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got wr=%b data=%02h drop=%0d, required all 0", fifo_write, fifo_data, lines_dropped);
        end
        idle(3);
        reset_n = 1'b1;
        idle(2);
        checks++; if (wr_cnt !== 700 || exp_q.size() !== 0) begin errors++; $display("FAIL mid_reset_writes: got %0d left=%0d, required 700/0", wr_cnt, exp_q.size()); end
        clear_counts();
        send_trs(8'h80, 1'b0, 1'b1);
        send_data(LB, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== LB || done_cnt !== 1 || short_cnt !== 0) begin
            errors++; $display("FAIL restart_line: got wr=%0d done=%0d short=%0d, required %0d/1/0", wr_cnt, done_cnt, short_cnt, LB);
        end
    endtask

    task automatic test_xy_check();
        int exp_wr;
        int exp_done;
        bit acc;
`ifdef BT656_XY_CHECK_EN
        acc = 1'b0; exp_wr = 0; exp_done = 0;
`else
        acc = 1'b1; exp_wr = LB; exp_done = 1;
`endif
        clear_counts();
        send_trs(8'h81, 1'b0, acc);
        send_data(LB, 1'b0);
        send_trs(8'h9D, 1'b0, 1'b1);
        idle(3);
        checks++; if (wr_cnt !== exp_wr || done_cnt !== exp_done) begin
            errors++; $display("FAIL xy_check: got wr=%0d done=%0d, required %0d/%0d", wr_cnt, done_cnt, exp_wr, exp_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_overrun();
        test_drop();
        test_short_long();
        test_vblank_field();
        test_back_to_back();
        test_gaps();
        test_reset_mid_line();
        test_xy_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
